result_checker: RTL

- Synthesizable self-checking monitor for the pipelined processor.
- Watches the fetched PC and sequences through NCHK checkpoints. At each checkpoint it waits a settle delay so the result reaches writeback, samples the data-memory output and compares it to an expected value.
- Keeps pass/fail counts and a watchdog that flags a hung program (infinite loop).
- Sits beside PipelinedProc in simulation and FPGA bring-up, replacing hand-written bench checks.

---
 rtl/result_checker.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/result_checker.sv
// Self-checking monitor for the pipelined processor: walks NCHK PC checkpoints, samples the
// data-memory output a fixed settle time after each hit, and tallies pass/fail with a watchdog.
module result_checker #(
  parameter int unsigned AW     = 64,
  parameter int unsigned DW     = 64,
  parameter int unsigned NCHK   = 2,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned WDW    = 16,
  parameter int unsigned CW     = 8,
  localparam int unsigned IW    = $clog2(NCHK) + 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [AW-1:0]     FetchedPC,
  input  logic [DW-1:0]     dMemOut,
  input  logic [NCHK*AW-1:0] chk_pc,
  input  logic [NCHK*DW-1:0] chk_val,
  output logic              busy,
  output logic              done,
  output logic              all_passed,
  output logic              timeout,
  output logic [CW-1:0]     pass_cnt,
  output logic [CW-1:0]     fail_cnt,
  output logic [IW-1:0]     chk_idx,
  output logic              mismatch,
  output logic [DW-1:0]     got_val
);

  localparam int unsigned SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitPc,
    StSettle,
    StCompare,
    StDone,
    StTimeout
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [CW-1:0]  pass_q, pass_d;
  logic [CW-1:0]  fail_q, fail_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           done_q, done_d;
  logic           allp_q, allp_d;
  logic           tmo_q, tmo_d;
  logic           mism_q, mism_d;
  logic [DW-1:0]  got_q, got_d;

  logic [AW-1:0]  cur_pc;
  logic [DW-1:0]  cur_val;
  logic [WDW-1:0] wdog_inc;
  logic           busy_w;
  logic           expire;

  // Select the threshold and expected value of the current checkpoint.
  always_comb begin
    cur_pc  = '0;
    cur_val = '0;
    for (int unsigned i = 0; i < NCHK; i++) begin
      if (idx_q == IW'(i)) begin
        cur_pc  = chk_pc[i*AW +: AW];
        cur_val = chk_val[i*DW +: DW];
      end
    end
  end

  assign busy_w   = (state_q == StWaitPc) || (state_q == StSettle) || (state_q == StCompare);
  assign wdog_inc = wdog_q + WDW'(1);
  // The counter is cleared on every start, so it never sits at all-ones while busy.
  assign expire   = busy_w && (wdog_inc == {WDW{1'b1}});

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    wdog_d   = wdog_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    idx_d    = idx_q;
    done_d   = done_q;
    allp_d   = allp_q;
    tmo_d    = tmo_q;
    mism_d   = 1'b0;
    got_d    = got_q;

    if (busy_w) begin
      wdog_d = wdog_inc;
    end

    unique case (state_q)
      StIdle, StDone, StTimeout: begin
        if (Start) begin
          state_d = StWaitPc;
          pass_d  = '0;
          fail_d  = '0;
          idx_d   = '0;
          wdog_d  = '0;
          tmo_d   = 1'b0;
          done_d  = 1'b0;
          allp_d  = 1'b0;
        end
      end
      StWaitPc: begin
        if (FetchedPC >= cur_pc) begin
          state_d  = StSettle;
          settle_d = SW'(SETTLE - 1);
        end
      end
      StSettle: begin
        if (settle_q == '0) begin
          state_d = StCompare;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      StCompare: begin
        got_d = dMemOut;
        if (dMemOut == cur_val) begin
          pass_d = (pass_q == {CW{1'b1}}) ? pass_q : pass_q + CW'(1);
        end else begin
          fail_d = (fail_q == {CW{1'b1}}) ? fail_q : fail_q + CW'(1);
          mism_d = 1'b1;
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NCHK - 1)) begin
          state_d = StDone;
          done_d  = 1'b1;
          allp_d  = (fail_d == '0) && (pass_d == CW'(NCHK));
        end else begin
          state_d = StWaitPc;
        end
      end
      default: state_d = StIdle;
    endcase

    // Watchdog expiry overrides any other transition, including the final compare.
    if (expire) begin
      state_d = StTimeout;
      tmo_d   = 1'b1;
      done_d  = 1'b1;
      allp_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= StIdle;
      settle_q <= '0;
      wdog_q   <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      allp_q   <= 1'b0;
      tmo_q    <= 1'b0;
      mism_q   <= 1'b0;
      got_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      wdog_q   <= wdog_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      allp_q   <= allp_d;
      tmo_q    <= tmo_d;
      mism_q   <= mism_d;
      got_q    <= got_d;
    end
  end

  assign busy       = busy_w;
  assign done       = done_q;
  assign all_passed = allp_q;
  assign timeout    = tmo_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign chk_idx    = idx_q;
  assign mismatch   = mism_q;
  assign got_val    = got_q;

endmodule
